ad_sample_ctrl: RTL and testbench

- Sequencer in front of the ADC averaging filter.
- Paces conversions at a programmed period and runs the ADC convert/done handshake with timeout.
- Delivers each captured sample as a one-cycle valid strobe to the filter input.
- Blanks the filter's output valid until the averaging window is refilled after enable or after an averaging-mode change; flags overruns and timeouts.

---
 rtl/ad_sample_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ad_sample_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad_sample_ctrl.sv
// ADC sample sequencer: paces conversions, runs the convert/done handshake with timeout,
// and blanks averaging-filter output until its window has refilled.
module ad_sample_ctrl #(
   parameter int unsigned CNV_W   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        cfg_en,
   input  logic [15:0] cfg_period,
   input  logic [7:0]  cfg_ave,
   input  logic        stat_clr,
   output logic        adc_cnv,
   input  logic        adc_done,
   input  logic [15:0] adc_data,
   output logic [15:0] ad_data_o,
   output logic        ad_vld_o,
   input  logic [15:0] filt_data_i,
   input  logic        filt_vld_i,
   output logic [15:0] filt_data_o,
   output logic        filt_vld_o,
   output logic        stat_ovr,
   output logic        stat_tmo
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CNV  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [15:0] P_MIN    = 16'(CNV_W + 32'd2);
   localparam logic [3:0]  CNV_LAST = 4'(CNV_W - 32'd1);
   localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 32'd1);

   // Samples the filter must see before its output is trustworthy, per averaging mode.
   function automatic logic [3:0] blank_n(input logic [1:0] mode);
      case (mode)
         2'd0:    blank_n = 4'd0;
         2'd1:    blank_n = 4'd3;
         2'd2:    blank_n = 4'd5;
         2'd3:    blank_n = 4'd9;
         default: blank_n = 4'd0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  cnv_cnt_q, cnv_cnt_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;
   logic        adc_cnv_q, adc_cnv_d;
   logic [15:0] ad_data_q, ad_data_d;
   logic        ad_vld_q, ad_vld_d;
   logic        ovr_q, ovr_d;
   logic        tmo_q, tmo_d;
   logic        en_q;
   logic [1:0]  ave_q;
   logic [3:0]  blank_q, blank_d;
   logic        filt_vld_q, filt_vld_d;
   logic [15:0] filt_data_q, filt_data_d;

   logic [15:0] period_eff;
   logic        tick;
   logic        ovr_set;
   logic        tmo_set;
   logic        reload;
   logic        ave_hi_unused;

   assign ave_hi_unused = ^cfg_ave[7:2];
   assign period_eff    = (cfg_period < P_MIN) ? P_MIN : cfg_period;
   assign tick          = cfg_en & (cnt_q == 16'd0);

   // Period counter: compares against the live period so a shortened period wraps promptly.
   always_comb begin
      cnt_d = cnt_q;
      if (!cfg_en) begin
         cnt_d = 16'd0;
      end else if (cnt_q >= (period_eff - 16'd1)) begin
         cnt_d = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Conversion FSM next state, handshake capture and status set events.
   always_comb begin
      state_d   = state_q;
      cnv_cnt_d = cnv_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      ad_data_d = ad_data_q;
      ad_vld_d  = 1'b0;
      ovr_set   = 1'b0;
      tmo_set   = 1'b0;
      if (!cfg_en) begin
         state_d   = ST_IDLE;
         cnv_cnt_d = 4'd0;
         tmo_cnt_d = 8'd0;
      end else begin
         ovr_set = tick & (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  state_d   = ST_CNV;
                  cnv_cnt_d = 4'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CNV: begin
               if (cnv_cnt_q == CNV_LAST) begin
                  state_d   = ST_WAIT;
                  tmo_cnt_d = 8'd0;
               end else begin
                  cnv_cnt_d = cnv_cnt_q + 4'd1;
               end
            end
            ST_WAIT: begin
               if (adc_done) begin
                  ad_data_d = adc_data;
                  ad_vld_d  = 1'b1;
                  state_d   = ST_IDLE;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  tmo_set = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      adc_cnv_d = (state_d == ST_CNV);
      ovr_d     = ovr_set | (ovr_q & ~stat_clr);
      tmo_d     = tmo_set | (tmo_q & ~stat_clr);
   end

   // Output blanking: a reload beats a same-cycle decrement.
   always_comb begin
      reload  = (cfg_en & ~en_q) | (cfg_ave[1:0] != ave_q);
      blank_d = blank_q;
      if (reload) begin
         blank_d = blank_n(cfg_ave[1:0]);
      end else if (filt_vld_i && (blank_q != 4'd0)) begin
         blank_d = blank_q - 4'd1;
      end else begin
         blank_d = blank_q;
      end
      filt_vld_d  = filt_vld_i & (blank_q == 4'd0);
      filt_data_d = filt_vld_i ? filt_data_i : filt_data_q;
   end

   // State and output registers.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 16'd0;
         cnv_cnt_q   <= 4'd0;
         tmo_cnt_q   <= 8'd0;
         adc_cnv_q   <= 1'b0;
         ad_data_q   <= 16'd0;
         ad_vld_q    <= 1'b0;
         ovr_q       <= 1'b0;
         tmo_q       <= 1'b0;
         en_q        <= 1'b0;
         ave_q       <= 2'd0;
         blank_q     <= 4'd0;
         filt_vld_q  <= 1'b0;
         filt_data_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cnv_cnt_q   <= cnv_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         adc_cnv_q   <= adc_cnv_d;
         ad_data_q   <= ad_data_d;
         ad_vld_q    <= ad_vld_d;
         ovr_q       <= ovr_d;
         tmo_q       <= tmo_d;
         en_q        <= cfg_en;
         ave_q       <= cfg_ave[1:0];
         blank_q     <= blank_d;
         filt_vld_q  <= filt_vld_d;
         filt_data_q <= filt_data_d;
      end
   end

   assign adc_cnv     = adc_cnv_q;
   assign ad_data_o   = ad_data_q;
   assign ad_vld_o    = ad_vld_q;
   assign filt_data_o = filt_data_q;
   assign filt_vld_o  = filt_vld_q;
   assign stat_ovr    = ovr_q;
   assign stat_tmo    = tmo_q;

endmodule

// File: tb/tb_ad_sample_ctrl.sv
// Directed bench for ad_sample_ctrl with an ADC responder and scoreboards for sample and
// filter strobes; a second instance with a short timeout covers the abort path.
module tb_ad_sample_ctrl;

   localparam int CNV_W = 4;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic        cfg_en;
   logic [15:0] cfg_period;
   logic [7:0]  cfg_ave;
   logic        stat_clr;
   logic        adc_done   = 1'b0;
   logic [15:0] adc_data   = 16'd0;
   logic        adc_done_t = 1'b0;
   logic [15:0] filt_data_i;
   logic        filt_vld_i;

   logic        adc_cnv, ad_vld_o, filt_vld_o, stat_ovr, stat_tmo;
   logic [15:0] ad_data_o, filt_data_o;
   logic        adc_cnv_t, ad_vld_t, filt_vld_t, stat_ovr_t, stat_tmo_t;
   logic [15:0] ad_data_t, filt_data_t;

   int          n_assert   = 0;
   int          n_fail     = 0;
   int          cyc        = 0;
   int          done_dly   = 3;
   int          cnv_len    = 0;
   int          wait_cnt   = 0;
   bit          armed      = 1'b0;
   logic [15:0] sample_val = 16'h1234;
   exp_t        ad_q[$];
   exp_t        filt_q[$];

   ad_sample_ctrl #(.CNV_W(CNV_W), .TIMEOUT(255)) u_dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_period(cfg_period),
      .cfg_ave(cfg_ave), .stat_clr(stat_clr), .adc_cnv(adc_cnv), .adc_done(adc_done),
      .adc_data(adc_data), .ad_data_o(ad_data_o), .ad_vld_o(ad_vld_o),
      .filt_data_i(filt_data_i), .filt_vld_i(filt_vld_i), .filt_data_o(filt_data_o),
      .filt_vld_o(filt_vld_o), .stat_ovr(stat_ovr), .stat_tmo(stat_tmo)
   );

   ad_sample_ctrl #(.CNV_W(CNV_W), .TIMEOUT(10)) u_tmo (
      .clk_sys(clk_sys), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_period(cfg_period),
      .cfg_ave(cfg_ave), .stat_clr(stat_clr), .adc_cnv(adc_cnv_t), .adc_done(adc_done_t),
      .adc_data(adc_data), .ad_data_o(ad_data_t), .ad_vld_o(ad_vld_t),
      .filt_data_i(filt_data_i), .filt_vld_i(filt_vld_i), .filt_data_o(filt_data_t),
      .filt_vld_o(filt_vld_t), .stat_ovr(stat_ovr_t), .stat_tmo(stat_tmo_t)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic filt_pulse(input logic [15:0] d, input bit pass);
      filt_vld_i  = 1'b1;
      filt_data_i = d;
      if (pass) filt_q.push_back('{d, cyc + 1});
      @(negedge clk_sys);
      filt_vld_i = 1'b0;
      chk("filt_vld", 32'(filt_vld_o), 32'(pass));
   endtask

   // ADC responder: answers only a full-width convert pulse, done_dly cycles after it falls.
   always begin
      @(negedge clk_sys);
      #1;
      adc_done = 1'b0;
      if (!rst_n) begin
         cnv_len = 0;
         armed   = 1'b0;
      end else if (adc_cnv) begin
         cnv_len++;
      end else begin
         if (cnv_len == CNV_W) begin
            armed    = 1'b1;
            wait_cnt = 0;
         end
         cnv_len = 0;
         if (armed) begin
            if (wait_cnt == done_dly) begin
               adc_done = 1'b1;
               adc_data = sample_val;
               if (cfg_en) ad_q.push_back('{sample_val, cyc + 1});
               sample_val = sample_val + 16'h0101;
               armed      = 1'b0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Sample strobe scoreboard.
   always @(negedge clk_sys) begin
      exp_t e;
      if (rst_n && ad_vld_o) begin
         chk("ad_vld_expected", 32'(ad_q.size() != 0), 32'd1);
         if (ad_q.size() != 0) begin
            e = ad_q.pop_front();
            chk("ad_data", 32'(ad_data_o), 32'(e.data));
            chk("ad_vld_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Filter strobe scoreboard.
   always @(negedge clk_sys) begin
      exp_t e;
      if (rst_n && filt_vld_o) begin
         chk("filt_vld_expected", 32'(filt_q.size() != 0), 32'd1);
         if (filt_q.size() != 0) begin
            e = filt_q.pop_front();
            chk("filt_data", 32'(filt_data_o), 32'(e.data));
            chk("filt_vld_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      cfg_en      = 1'b0;
      cfg_period  = 16'd20;
      cfg_ave     = 8'd0;
      stat_clr    = 1'b0;
      filt_vld_i  = 1'b0;
      filt_data_i = 16'd0;
      repeat (3) @(negedge clk_sys);
      chk("rst_flags", 32'({adc_cnv, ad_vld_o, filt_vld_o, stat_ovr, stat_tmo}), 32'd0);
      chk("rst_data", {ad_data_o, filt_data_o}, 32'd0);
      chk("rst_tmo_flags", 32'({adc_cnv_t, ad_vld_t, filt_vld_t, stat_ovr_t, stat_tmo_t}), 32'd0);
      chk("rst_tmo_data", {ad_data_t, filt_data_t}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // Pacing/handshake on the main instance, timeout/clear on the short-timeout one.
      cfg_en = 1'b1;
      for (int c = 1; c <= 44; c++) begin
         @(negedge clk_sys);
         chk("t1_adc_cnv", 32'(((c % 20) >= 1) && ((c % 20) <= 4)), 32'(adc_cnv));
         chk("t1_ad_vld", 32'(ad_vld_o), 32'((c == 9) || (c == 29)));
         if (c == 9) chk("t1_ad_data", 32'(ad_data_o), 32'h1234);
         chk("t1_stat_ovr", 32'(stat_ovr), 32'd0);
         chk("t3_adc_cnv", 32'(adc_cnv_t), 32'(((c % 20) >= 1) && ((c % 20) <= 4)));
         chk("t3_stat_tmo", 32'(stat_tmo_t), 32'(((c >= 15) && (c <= 22)) || (c >= 35)));
         chk("t3_ad_vld", 32'(ad_vld_t), 32'd0);
         stat_clr = (c == 22) || (c == 34);
      end
      cfg_en = 1'b0;
      repeat (10) @(negedge clk_sys);

      // Period clamp: cfg_period=2 runs at 6.
      cfg_period = 16'd2;
      done_dly   = 0;
      cfg_en     = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk_sys);
         chk("t2_adc_cnv", 32'(adc_cnv), 32'(((c % 6) >= 1) && ((c % 6) <= 4)));
         chk("t2_ad_vld", 32'(ad_vld_o), 32'((c % 6) == 0));
      end
      chk("t2_stat_ovr", 32'(stat_ovr), 32'd0);
      cfg_en = 1'b0;
      repeat (10) @(negedge clk_sys);

      // Overrun: slow ADC, tick at 20 dropped.
      cfg_period = 16'd20;
      done_dly   = 30;
      cfg_en     = 1'b1;
      for (int c = 1; c <= 42; c++) begin
         @(negedge clk_sys);
         chk("t4_adc_cnv", 32'(adc_cnv), 32'(((c >= 1) && (c <= 4)) || (c >= 41)));
         chk("t4_stat_ovr", 32'(stat_ovr), 32'(c >= 21));
         chk("t4_ad_vld", 32'(ad_vld_o), 32'(c == 36));
      end
      cfg_en   = 1'b0;
      stat_clr = 1'b1;
      @(negedge clk_sys);
      stat_clr = 1'b0;
      chk("t4_ovr_clr", 32'(stat_ovr), 32'd0);
      repeat (8) @(negedge clk_sys);

      // Blanking: mode 2, then 3 mid-stream, then 0.
      done_dly = 3;
      cfg_ave  = 8'd2;
      repeat (2) @(negedge clk_sys);
      cfg_en = 1'b1;
      repeat (2) @(negedge clk_sys);
      for (int i = 0; i < 8; i++) filt_pulse(16'hA000 + 16'(i), (i >= 5));
      cfg_ave = 8'd3;
      @(negedge clk_sys);
      for (int i = 0; i < 10; i++) filt_pulse(16'hB000 + 16'(i), (i == 9));
      cfg_ave = 8'd0;
      @(negedge clk_sys);
      for (int i = 0; i < 3; i++) filt_pulse(16'hC000 + 16'(i), 1'b1);
      cfg_en = 1'b0;
      repeat (10) @(negedge clk_sys);

      // Disable during convert, then re-enable with a fresh blanking window.
      cfg_ave = 8'd1;
      repeat (3) @(negedge clk_sys);
      cfg_en = 1'b1;
      @(negedge clk_sys);
      chk("t6_cnv_c1", 32'(adc_cnv), 32'd1);
      filt_pulse(16'hD000, 1'b0);
      chk("t6_cnv_c2", 32'(adc_cnv), 32'd1);
      cfg_en = 1'b0;
      for (int c = 3; c <= 12; c++) begin
         @(negedge clk_sys);
         chk("t6_cnv_off", 32'(adc_cnv), 32'd0);
         chk("t6_ad_vld", 32'(ad_vld_o), 32'd0);
      end
      cfg_en = 1'b1;
      @(negedge clk_sys);
      chk("t6_reen_cnv", 32'(adc_cnv), 32'd1);
      for (int i = 0; i < 4; i++) filt_pulse(16'hE000 + 16'(i), (i == 3));
      cfg_en = 1'b0;
      repeat (40) @(negedge clk_sys);

      chk("ad_q_drained", 32'(ad_q.size()), 32'd0);
      chk("filt_q_drained", 32'(filt_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
